// File: rtl/rsign_pkg.sv
// Shared types for the RSign parameter loader.
package rsign_pkg;

    // Loader phases: wait for reload mode, take words, copy shadow to active, hold.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } rsign_ld_state_t;

endpackage

// File: rtl/defines.v
// Shared data-width and polarity macros for the RSign datapath.
`ifndef RSIGN_DEFINES_V
`define RSIGN_DEFINES_V

// Width of one signed RSign threshold word.
`define PARA_WIDTH 8

// Level of rst_n that holds the design in reset.
`define RSTVALID 1'b0

// Level of mode that selects calculate (HIGH) rather than reload (LOW).
`define CALCULATE 1'b1

`endif

// File: rtl/rsign_para_loader.sv
// rsign_para_loader: word-serial writer for the per-channel signed RSign
// threshold array. Words arrive over valid/ready into a shadow buffer while
// mode is LOW; once the full set is in, the shadow is copied to the active
// array on a single edge so calculate-mode consumers never see a mixed set.
`include "defines.v"

module rsign_para_loader
    import rsign_pkg::*;
#(
    parameter  int FM_DEPTH = 256,
    localparam int CNT_W    = (FM_DEPTH > 1) ? $clog2(FM_DEPTH) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mode,
    input  logic                          para_valid,
    input  logic signed [`PARA_WIDTH-1:0] para_in,
    output logic                          para_ready,
    output logic signed [`PARA_WIDTH-1:0] para [FM_DEPTH],
    output logic                          load_done,
    output logic                          load_err,
    output logic [CNT_W-1:0]              word_cnt
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FM_DEPTH - 1);

    rsign_ld_state_t               r_state;
    rsign_ld_state_t               w_next_state;
    logic signed [`PARA_WIDTH-1:0] r_shadow [FM_DEPTH];
    logic signed [`PARA_WIDTH-1:0] r_para   [FM_DEPTH];
    logic [CNT_W-1:0]              r_word_cnt;
    logic                          r_para_ready;
    logic                          r_load_done;
    logic                          r_load_err;

    logic w_calc;
    logic w_xfer;
    logic w_final;
    logic w_abort;
    logic w_commit;
    logic w_ready_nxt;
    logic w_done_nxt;
    logic w_err_nxt;

    // A word moves only when the registered ready is already high this cycle.
    assign w_calc  = (mode == `CALCULATE);
    assign w_xfer  = para_valid && r_para_ready;
    assign w_final = w_xfer && (r_word_cnt == LAST_IDX);
    // The last word wins over a simultaneous switch to calculate mode.
    assign w_abort = (r_state == LOAD) && w_calc && !w_final;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: a new load requires mode to pass through HIGH after DONE.
    // NOTE: the default assignment up front keeps this block free of latches
    // even when a case arm leaves the state untouched.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:   if (!w_calc) w_next_state = LOAD;
            LOAD: begin
                if (w_final) begin
                    w_next_state = COMMIT;
                end else if (w_calc) begin
                    w_next_state = IDLE;
                end
            end
            COMMIT: w_next_state = DONE;
            DONE:   if (w_calc) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode: values the status registers take on the coming edge.
    always_comb begin
        w_ready_nxt = (w_next_state == LOAD);
        w_commit    = (r_state == COMMIT);
        w_done_nxt  = w_commit;
        w_err_nxt   = w_abort;
    end

    // Registered handshake ready and one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_para_ready <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_para_ready <= w_ready_nxt;
            r_load_done  <= w_done_nxt;
            r_load_err   <= w_err_nxt;
        end
    end

    // Word index: cleared outside a load and on abort, wraps after the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt <= '0;
        end else if ((r_state == IDLE) || w_abort) begin
            r_word_cnt <= '0;
        end else if (w_xfer) begin
            r_word_cnt <= w_final ? '0 : r_word_cnt + 1'b1;
        end
    end

    // Shadow buffer: each accepted word lands at the current index, bit-exact.
    // NOTE: this storage is reset on purpose so a reset mid-load leaves no
    // stale partial set behind; that forces it into flops rather than RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FM_DEPTH; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_xfer) begin
            r_shadow[r_word_cnt] <= para_in;
        end
    end

    // Active array: copied from the shadow as a whole, only during COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FM_DEPTH; i++) begin
                r_para[i] <= '0;
            end
        end else if (w_commit) begin
            r_para <= r_shadow;
        end
    end

    assign para_ready = r_para_ready;
    assign para       = r_para;
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;
    assign word_cnt   = r_word_cnt;

endmodule
